// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retirement of CDB-completed entries with commit, store-release and mispredict rollback.
// Optional: define ROB_CDB_BYPASS_EN to let operand queries see a same-cycle CDB broadcast.
module reorder_buffer #(
  parameter int ROB_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                issue_valid,
  input  logic [1:0]          issue_type,
  input  logic [4:0]          issue_rd,
  input  logic                issue_pred_taken,
  output logic [ROB_BITS-1:0] issue_tag,
  output logic                rob_full,
  input  logic [ROB_BITS-1:0] query_tag_j,
  input  logic [ROB_BITS-1:0] query_tag_k,
  output logic                query_ready_j,
  output logic                query_ready_k,
  output logic [31:0]         query_val_j,
  output logic [31:0]         query_val_k,
  input  logic                cdb_valid,
  input  logic [ROB_BITS-1:0] cdb_tag,
  input  logic [31:0]         cdb_val,
  input  logic                cdb_taken,
  output logic                commit_valid,
  output logic [4:0]          ROB_rd,
  output logic [ROB_BITS-1:0] ROB_rdTag,
  output logic [31:0]         ROB_rdVal,
  output logic                commit_store,
  output logic [ROB_BITS-1:0] commit_store_tag,
  output logic                rollback,
  output logic [31:0]         rollback_pc
);

  localparam int DEPTH = 1 << ROB_BITS;

  typedef logic [ROB_BITS-1:0] tag_t;
  typedef logic [ROB_BITS:0]   cnt_t;
  typedef enum logic [1:0] {
    T_REG    = 2'b00,
    T_BRANCH = 2'b01,
    T_STORE  = 2'b10,
    T_RSVD   = 2'b11
  } rob_type_e;

  tag_t             head, tail;
  cnt_t             count;
  logic [DEPTH-1:0] busy, ready;

  rob_type_e        typ_q   [DEPTH];
  logic [4:0]       rd_q    [DEPTH];
  logic [31:0]      val_q   [DEPTH];
  logic [DEPTH-1:0] pred_q, taken_q;

  logic commit_fire, mispredict, issue_fire, cdb_fire;

  assign issue_tag = tail;
  assign rob_full  = (count == cnt_t'(DEPTH));

  // Retirement is decided from registered state only, so a result
  // captured at one edge retires at the following edge.
  assign commit_fire = rdy & busy[head] & ready[head];
  assign mispredict  = commit_fire && (typ_q[head] == T_BRANCH) &&
                       (taken_q[head] != pred_q[head]);
  assign issue_fire  = rdy & issue_valid & ~rob_full & ~rollback & ~mispredict;
  assign cdb_fire    = rdy & cdb_valid & busy[cdb_tag] & ~mispredict;

  // NOTE: payload storage has no reset; busy/ready gate every read, so
  // only the flag vectors need to come out of reset clean.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      typ_q[tail]  <= rob_type_e'(issue_type);
      rd_q[tail]   <= issue_rd;
      pred_q[tail] <= issue_pred_taken;
    end
    if (cdb_fire) begin
      val_q[cdb_tag]   <= cdb_val;
      taken_q[cdb_tag] <= cdb_taken;
    end
  end

  // NOTE: all state here uses non-blocking assignments; later writes in
  // the block (retire, then flush) deliberately override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      ready            <= '0;
      commit_valid     <= 1'b0;
      ROB_rd           <= '0;
      ROB_rdTag        <= '0;
      ROB_rdVal        <= '0;
      commit_store     <= 1'b0;
      commit_store_tag <= '0;
      rollback         <= 1'b0;
      rollback_pc      <= '0;
    end else if (rdy) begin
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      rollback     <= 1'b0;

      if (cdb_fire) ready[cdb_tag] <= 1'b1;

      if (issue_fire) begin
        busy[tail]  <= 1'b1;
        // Stores carry no CDB result and are complete at issue.
        ready[tail] <= (rob_type_e'(issue_type) == T_STORE);
        tail        <= tail + tag_t'(1);
      end

      if (commit_fire) begin
        busy[head] <= 1'b0;
        head       <= head + tag_t'(1);
        case (typ_q[head])
          T_REG: begin
            commit_valid <= 1'b1;
            ROB_rd       <= rd_q[head];
            ROB_rdTag    <= head;
            ROB_rdVal    <= val_q[head];
          end
          T_STORE: begin
            commit_store     <= 1'b1;
            commit_store_tag <= head;
          end
          T_BRANCH: begin
            if (mispredict) begin
              rollback    <= 1'b1;
              rollback_pc <= val_q[head];
            end
          end
          default: ;
        endcase
      end

      if (mispredict) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        count <= count + cnt_t'(issue_fire) - cnt_t'(commit_fire);
      end
    end
  end

  // NOTE: every output gets a default before any conditional override so
  // this block stays purely combinational.
  always_comb begin
    query_ready_j = busy[query_tag_j] & ready[query_tag_j];
    query_ready_k = busy[query_tag_k] & ready[query_tag_k];
    query_val_j   = query_ready_j ? val_q[query_tag_j] : 32'h0;
    query_val_k   = query_ready_k ? val_q[query_tag_k] : 32'h0;
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && busy[query_tag_j] && (cdb_tag == query_tag_j)) begin
      query_ready_j = 1'b1;
      query_val_j   = cdb_val;
    end
    if (cdb_valid && busy[query_tag_k] && (cdb_tag == query_tag_k)) begin
      query_ready_k = 1'b1;
      query_val_k   = cdb_val;
    end
`else
    // Queries reflect registered entries only; a broadcast shows up next cycle.
`endif
  end

endmodule
